ps2_key_tracker: RTL and testbench

- Consumes PS/2 scan-code bytes from the keyboard receiver FIFO using a ready/nextdata_n pop handshake.
- Tracks key make, break and E0-extended sequences in an FSM, and counts completed keystrokes.
- Drives a parametrised bank of seven-segment digits showing the held scan code, its ASCII value and the keystroke count.
- Sits between the PS/2 receiver and the board seven-segment pins; the external ASCII lookup ROM is driven from code_out.

---
 rtl/ps2_key_tracker.sv | 172 +++++++++++++++++
 tb/tb_ps2_key_tracker.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_tracker.sv
// PS/2 scan-code tracker: pops bytes from the receiver FIFO, follows make/break/E0 sequences,
// counts keystrokes and drives a seven-segment bank (code, ASCII, count).
module ps2_key_tracker #(
  parameter int CNT_W          = 8,
  parameter int CNT_SAT        = 0,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int NDIG           = 4 + CNT_W/4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ready,
  input  logic [7:0]          data,
  output logic                nextdata_n,
  output logic [7:0]          code_out,
  input  logic [7:0]          ascii_in,
  output logic                key_valid,
  output logic                key_ext,
  output logic [CNT_W-1:0]    count,
  output logic [8*NDIG-1:0]   o_seg
);

  localparam int unsigned NCNT = CNT_W / 4;
  localparam logic [8*NDIG-1:0] SEG_MASK = (SEG_ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HELD,
    S_EXT,
    S_BRK,
    S_EXT_BRK
  } state_t;

  state_t             state_q;
  logic               wait_q;
  logic               nextdata_n_q;
  logic [7:0]         byte_q;
  logic [7:0]         code_q;
  logic               valid_q;
  logic               ext_q;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;
  logic [8*NDIG-1:0]  seg_q;
  logic [8*NDIG-1:0]  seg_d;
  logic [8*NDIG-1:0]  seg_raw;
  logic               ascii_on;
  logic               take;
  logic               is_prefix;

  function automatic logic [7:0] hex7(input logic [3:0] n);
    case (n)
      4'h0:    hex7 = 8'hFC;
      4'h1:    hex7 = 8'h60;
      4'h2:    hex7 = 8'hDA;
      4'h3:    hex7 = 8'hF2;
      4'h4:    hex7 = 8'h66;
      4'h5:    hex7 = 8'hB6;
      4'h6:    hex7 = 8'hBE;
      4'h7:    hex7 = 8'hE0;
      4'h8:    hex7 = 8'hFE;
      4'h9:    hex7 = 8'hF6;
      4'hA:    hex7 = 8'hEE;
      4'hB:    hex7 = 8'h3E;
      4'hC:    hex7 = 8'h9C;
      4'hD:    hex7 = 8'h7A;
      4'hE:    hex7 = 8'h9E;
      default: hex7 = 8'h8E;
    endcase
  endfunction

  // The cycle after a pop is a dead cycle so the FIFO head can advance before ready is trusted again.
  assign take      = ready && !wait_q && nextdata_n_q;
  assign is_prefix = (byte_q == 8'hE0) || (byte_q == 8'hF0);

  always_comb begin
    if ((CNT_SAT != 0) && (count_q == '1)) begin
      count_d = count_q;
    end else begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      wait_q       <= 1'b0;
      nextdata_n_q <= 1'b1;
      byte_q       <= '0;
      code_q       <= '0;
      valid_q      <= 1'b0;
      ext_q        <= 1'b0;
      count_q      <= '0;
      seg_q        <= SEG_MASK;
    end else begin
      wait_q       <= 1'b0;
      nextdata_n_q <= 1'b1;
      seg_q        <= seg_d;
      if (take) begin
        byte_q       <= data;
        wait_q       <= 1'b1;
        nextdata_n_q <= 1'b0;
      end
      if (wait_q) begin
        case (state_q)
          S_IDLE, S_HELD: begin
            if (byte_q == 8'hE0) begin
              state_q <= S_EXT;
            end else if (byte_q == 8'hF0) begin
              state_q <= S_BRK;
            end else begin
              state_q <= S_HELD;
              code_q  <= byte_q;
              ext_q   <= 1'b0;
              valid_q <= 1'b1;
            end
          end
          S_EXT: begin
            if (byte_q == 8'hF0) begin
              state_q <= S_EXT_BRK;
            end else if (byte_q == 8'hE0) begin
              state_q <= S_EXT;
            end else begin
              state_q <= S_HELD;
              code_q  <= byte_q;
              ext_q   <= 1'b1;
              valid_q <= 1'b1;
            end
          end
          S_BRK, S_EXT_BRK: begin
            if (!is_prefix) begin
              count_q <= count_d;
              // Only a release of the displayed key (same code and same E0 flavour) clears it.
              if (valid_q && (byte_q == code_q) && (ext_q == (state_q == S_EXT_BRK))) begin
                state_q <= S_IDLE;
                code_q  <= '0;
                ext_q   <= 1'b0;
                valid_q <= 1'b0;
              end else begin
                state_q <= valid_q ? S_HELD : S_IDLE;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    seg_raw  = '0;
    ascii_on = valid_q && (ascii_in != 8'h00);
    if (valid_q) begin
      seg_raw[7:0]  = hex7(code_q[3:0]);
      seg_raw[15:8] = hex7(code_q[7:4]) | {7'b0, ext_q};
    end
    if (ascii_on) begin
      seg_raw[23:16] = hex7(ascii_in[3:0]);
      seg_raw[31:24] = hex7(ascii_in[7:4]);
    end
    for (int unsigned i = 0; i < NCNT; i++) begin
      seg_raw[32 + 8*i +: 8] = hex7(count_q[4*i +: 4]);
    end
    seg_d = seg_raw ^ SEG_MASK;
  end

  assign nextdata_n = nextdata_n_q;
  assign code_out   = code_q;
  assign key_valid  = valid_q;
  assign key_ext    = ext_q;
  assign count      = count_q;
  assign o_seg      = seg_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker: one default instance plus 4-bit wrap and saturate instances on shared stimulus.
module tb_ps2_key_tracker;

  typedef struct packed {
    logic [7:0] b;
    logic [7:0] code;
    logic       v;
    logic       e;
    logic [7:0] cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ready = 1'b0;
  logic [7:0]  data = 8'h00;

  logic        nd_m, nd_w, nd_s;
  logic [7:0]  code_m, code_w, code_s;
  logic [7:0]  asc_m, asc_w, asc_s;
  logic        v_m, v_w, v_s;
  logic        e_m, e_w, e_s;
  logic [7:0]  cnt_m;
  logic [3:0]  cnt_w, cnt_s;
  logic [47:0] seg_m;
  logic [39:0] seg_w, seg_s;

  int checks = 0;
  int failures = 0;
  vec_t tbl[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  function automatic logic [7:0] rom(input logic [7:0] c);
    case (c)
      8'h1C:   rom = 8'h61;
      8'h32:   rom = 8'h62;
      8'h5A:   rom = 8'h0D;
      default: rom = 8'h00;
    endcase
  endfunction

  assign asc_m = rom(code_m);
  assign asc_w = rom(code_w);
  assign asc_s = rom(code_s);

  ps2_key_tracker u_main (
    .clk(clk), .rst(rst), .ready(ready), .data(data), .nextdata_n(nd_m), .code_out(code_m),
    .ascii_in(asc_m), .key_valid(v_m), .key_ext(e_m), .count(cnt_m), .o_seg(seg_m)
  );

  ps2_key_tracker #(.CNT_W(4), .CNT_SAT(0)) u_wrap (
    .clk(clk), .rst(rst), .ready(ready), .data(data), .nextdata_n(nd_w), .code_out(code_w),
    .ascii_in(asc_w), .key_valid(v_w), .key_ext(e_w), .count(cnt_w), .o_seg(seg_w)
  );

  ps2_key_tracker #(.CNT_W(4), .CNT_SAT(1)) u_sat (
    .clk(clk), .rst(rst), .ready(ready), .data(data), .nextdata_n(nd_s), .code_out(code_s),
    .ascii_in(asc_s), .key_valid(v_s), .key_ext(e_s), .count(cnt_s), .o_seg(seg_s)
  );

  // Active-high a..g,dp patterns, written out independently of the design.
  function automatic logic [7:0] segpat(input logic [3:0] n);
    logic [7:0] t [16];
    t = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
          8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};
    segpat = t[n];
  endfunction

  function automatic logic [47:0] exp_seg(input vec_t x);
    logic [7:0] a;
    logic [7:0] d [6];
    a = rom(x.code);
    d[0] = x.v ? segpat(x.code[3:0]) : 8'h00;
    d[1] = x.v ? (segpat(x.code[7:4]) | {7'b0, x.e}) : 8'h00;
    d[2] = (x.v && a != 8'h00) ? segpat(a[3:0]) : 8'h00;
    d[3] = (x.v && a != 8'h00) ? segpat(a[7:4]) : 8'h00;
    d[4] = segpat(x.cnt[3:0]);
    d[5] = segpat(x.cnt[7:4]);
    exp_seg = ~{d[5], d[4], d[3], d[2], d[1], d[0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] b, input logic [7:0] code, input logic v, input logic e,
                     input logic [7:0] cnt);
    tbl.push_back('{b: b, code: code, v: v, e: e, cnt: cnt});
  endtask

  task automatic send_byte(input vec_t x);
    vec_t ex;
    bit   got;
    logic [3:0] sat;
    got = 0;
    @(negedge clk);
    ready = 1'b1;
    data  = x.b;
    sb.push_back(x);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (nd_m === 1'b0) begin
        got = 1;
        break;
      end
    end
    ready = 1'b0;
    if (!got) begin
      chk("pop_timeout", 64'(nd_m), 64'h0);
      void'(sb.pop_back());
      return;
    end
    @(negedge clk);
    chk("pop_one_cycle", 64'(nd_m), 64'h1);
    if (sb.size() == 0) begin
      chk("sb_empty", 64'h1, 64'h0);
      return;
    end
    ex  = sb.pop_front();
    sat = (ex.cnt > 8'd15) ? 4'hF : ex.cnt[3:0];
    chk("code_out", 64'(code_m), 64'(ex.code));
    chk("key_valid", 64'(v_m), 64'(ex.v));
    chk("key_ext", 64'(e_m), 64'(ex.e));
    chk("count", 64'(cnt_m), 64'(ex.cnt));
    chk("count_wrap4", 64'(cnt_w), 64'(ex.cnt[3:0]));
    chk("count_sat4", 64'(cnt_s), 64'(sat));
    @(negedge clk);
    chk("o_seg", 64'(seg_m), 64'(exp_seg(ex)));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pops;
    bit got;

    // make / break
    add(8'h1C, 8'h1C, 1, 0, 0);  add(8'hF0, 8'h1C, 1, 0, 0);  add(8'h1C, 8'h00, 0, 0, 1);
    // typematic
    add(8'h1C, 8'h1C, 1, 0, 1);  add(8'h1C, 8'h1C, 1, 0, 1);  add(8'h1C, 8'h1C, 1, 0, 1);
    add(8'hF0, 8'h1C, 1, 0, 1);  add(8'h1C, 8'h00, 0, 0, 2);
    // extended key, unmapped ASCII
    add(8'hE0, 8'h00, 0, 0, 2);  add(8'h75, 8'h75, 1, 1, 2);  add(8'hE0, 8'h75, 1, 1, 2);
    add(8'hF0, 8'h75, 1, 1, 2);  add(8'h75, 8'h00, 0, 0, 3);
    // rollover
    add(8'h1C, 8'h1C, 1, 0, 3);  add(8'h32, 8'h32, 1, 0, 3);  add(8'hF0, 8'h32, 1, 0, 3);
    add(8'h1C, 8'h32, 1, 0, 4);  add(8'hF0, 8'h32, 1, 0, 4);  add(8'h32, 8'h00, 0, 0, 5);
    // E0-break of a non-extended held key does not release it
    add(8'h1C, 8'h1C, 1, 0, 5);  add(8'hE0, 8'h1C, 1, 0, 5);  add(8'hF0, 8'h1C, 1, 0, 5);
    add(8'h1C, 8'h1C, 1, 0, 6);  add(8'hF0, 8'h1C, 1, 0, 6);  add(8'h1C, 8'h00, 0, 0, 7);
    // prefixes discarded in BRK, release of nothing held
    add(8'hF0, 8'h00, 0, 0, 7);  add(8'hE0, 8'h00, 0, 0, 7);  add(8'h5A, 8'h00, 0, 0, 8);

    repeat (2) @(negedge clk);
    chk("rst_seg_blank", 64'(seg_m), 64'hFFFF_FFFF_FFFF);
    chk("rst_nextdata_n", 64'(nd_m), 64'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_nextdata_n_idle", 64'(nd_m), 64'h1);
    chk("rst_count", 64'(cnt_m), 64'h0);
    chk("rst_code", 64'(code_m), 64'h0);
    chk("rst_valid", 64'(v_m), 64'h0);
    chk("rst_seg", 64'(seg_m), 64'h0303_FFFF_FFFF);

    foreach (tbl[i]) send_byte(tbl[i]);

    // ready held high: one pop every two cycles while the key auto-repeats
    send_byte('{b: 8'h1C, code: 8'h1C, v: 1, e: 0, cnt: 8});
    @(negedge clk);
    ready = 1'b1;
    data  = 8'h1C;
    pops  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (nd_m === 1'b0) pops++;
    end
    ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("held_ready_pops", 64'(pops), 64'd10);
    chk("typematic_code", 64'(code_m), 64'h1C);
    chk("typematic_count", 64'(cnt_m), 64'd8);
    send_byte('{b: 8'hF0, code: 8'h1C, v: 1, e: 0, cnt: 8});
    send_byte('{b: 8'h1C, code: 8'h00, v: 0, e: 0, cnt: 9});

    // 16 keystrokes from zero: 4-bit wrap returns to 0, saturating stops at F
    do_reset();
    for (int k = 0; k < 16; k++) begin
      send_byte('{b: 8'h1C, code: 8'h1C, v: 1, e: 0, cnt: 8'(k)});
      send_byte('{b: 8'hF0, code: 8'h1C, v: 1, e: 0, cnt: 8'(k)});
      send_byte('{b: 8'h1C, code: 8'h00, v: 0, e: 0, cnt: 8'(k + 1)});
    end
    chk("wrap4_final", 64'(cnt_w), 64'h0);
    chk("sat4_final", 64'(cnt_s), 64'hF);

    // reset after F0 with a pop pending: no increment, back to IDLE
    send_byte('{b: 8'h1C, code: 8'h1C, v: 1, e: 0, cnt: 16});
    send_byte('{b: 8'hF0, code: 8'h1C, v: 1, e: 0, cnt: 16});
    @(negedge clk);
    ready = 1'b1;
    data  = 8'h1C;
    got   = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (nd_m === 1'b0) begin
        got = 1;
        break;
      end
    end
    chk("midrst_pop_seen", 64'(got), 64'h1);
    rst   = 1'b0;
    ready = 1'b0;
    @(negedge clk);
    chk("midrst_nextdata_n", 64'(nd_m), 64'h1);
    chk("midrst_count", 64'(cnt_m), 64'h0);
    chk("midrst_valid", 64'(v_m), 64'h0);
    rst = 1'b1;
    @(negedge clk);
    send_byte('{b: 8'h1C, code: 8'h1C, v: 1, e: 0, cnt: 0});
    send_byte('{b: 8'hF0, code: 8'h1C, v: 1, e: 0, cnt: 0});
    send_byte('{b: 8'h1C, code: 8'h00, v: 0, e: 0, cnt: 1});

    chk("sb_drained", 64'(sb.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
